// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
// Two-requester write arbiter in front of an asymmetric FIFO. Each grant lets
// one requester push up to BURST write words (2*DATA_WIDTH bits each). Ties
// are broken against whoever was served last, so the two ports alternate.
//
// Ports
//   clk     : sole clock, rising edge
//   reset   : synchronous, active-high
//   req0/1  : requester n has a word waiting on datan
//   data0/1 : requester write words (2*DATA_WIDTH)
//   full    : FIFO full flag
//   wr      : FIFO write strobe
//   w_data  : FIFO write word (zero when idle)
//   ack0/1  : word on datan accepted this cycle
//   gnt     : registered one-hot grant (2'b01 port 0, 2'b10 port 1, 2'b00 idle)
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int BURST      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req0,
   input  logic [2*DATA_WIDTH-1:0] data0,
   input  logic                    req1,
   input  logic [2*DATA_WIDTH-1:0] data1,
   input  logic                    full,
   output logic                    wr,
   output logic [2*DATA_WIDTH-1:0] w_data,
   output logic                    ack0,
   output logic                    ack1,
   output logic [1:0]              gnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_last;
   logic [1:0] r_gnt;

   logic       w_ownReq;
   logic       w_otherReq;
   logic       w_grantEnd;

   // Pick out the request belonging to the current owner and the one from the
   // competing port, and steer the owner's data onto the FIFO bus. When idle
   // nothing is owned, so the bus is driven to zero.
   always_comb begin
      w_ownReq   = 1'b0;
      w_otherReq = 1'b0;
      w_data     = '0;
      case (r_state)
         OWN0: begin
            w_ownReq   = req0;
            w_otherReq = req1;
            w_data     = data0;
         end
         OWN1: begin
            w_ownReq   = req1;
            w_otherReq = req0;
            w_data     = data1;
         end
         default: begin
            w_ownReq   = 1'b0;
            w_otherReq = 1'b0;
            w_data     = '0;
         end
      endcase
   end

   // A write happens only while someone owns the bus, still has a word and the
   // FIFO has room. The ack goes to the owner in the same cycle. The grant
   // ends when the owner lets go or its final burst word is written; a drop
   // of req always wins over the burst limit since no word moves that cycle.
   assign wr         = w_ownReq & ~full;
   assign ack0       = (r_state == OWN0) & wr;
   assign ack1       = (r_state == OWN1) & wr;
   assign w_grantEnd = ~w_ownReq | (wr & (r_cnt == LAST_CNT));
   assign gnt        = r_gnt;

   // Arbitration state machine with burst counter and last-served tracking.
   // Reset marks port 1 as last served so port 0 wins the first tie. While
   // full stalls an owner that still requests, state and counter simply hold.
   // At grant end the other port gets the bus directly if it is waiting,
   // otherwise the same owner restarts a fresh burst, otherwise go idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_last  <= 1'b1;
         r_gnt   <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= 4'd0;
               if (req0 & (~req1 | r_last)) begin
                  r_state <= OWN0;
                  r_gnt   <= 2'b01;
               end else if (req1) begin
                  r_state <= OWN1;
                  r_gnt   <= 2'b10;
               end
            end
            OWN0, OWN1: begin
               if (w_grantEnd) begin
                  r_last <= (r_state == OWN1);
                  r_cnt  <= 4'd0;
                  if (w_otherReq) begin
                     r_state <= (r_state == OWN0) ? OWN1 : OWN0;
                     r_gnt   <= (r_state == OWN0) ? 2'b10 : 2'b01;
                  end else if (!w_ownReq) begin
                     r_state <= IDLE;
                     r_gnt   <= 2'b00;
                  end
               end else if (wr) begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 4'd0;
               r_gnt   <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
// Self-checking bench for fifo_wr_arb (DATA_WIDTH=8, BURST=4). Each step
// drives inputs on the falling edge, queues the expected outputs and compares
// them a moment later, before the next rising edge. A background monitor
// watches the write/ack/grant invariants every cycle.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

   localparam int DW = 8;
   localparam logic [15:0] D0 = 16'h3C5A;
   localparam logic [15:0] D1 = 16'hA5C3;

   typedef struct {
      logic        rst;
      logic        r0;
      logic        r1;
      logic        f;
      logic        chk;
      logic        ewr;
      logic [15:0] edata;
      logic        ea0;
      logic        ea1;
      logic [1:0]  egnt;
      int          step;
   } vec_t;

   logic          clk;
   logic          reset;
   logic          req0;
   logic [2*DW-1:0] data0;
   logic          req1;
   logic [2*DW-1:0] data1;
   logic          full;
   logic          wr;
   logic [2*DW-1:0] w_data;
   logic          ack0;
   logic          ack1;
   logic [1:0]    gnt;

   int    checks = 0;
   int    errors = 0;
   int    stepNo = 0;
   bit    done   = 1'b0;
   string curSeq = "none";
   vec_t  sbQ[$];
   vec_t  tbl[$];

   fifo_wr_arb #(.DATA_WIDTH(DW), .BURST(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .data0  (data0),
      .req1   (req1),
      .data1  (data1),
      .full   (full),
      .wr     (wr),
      .w_data (w_data),
      .ack0   (ack0),
      .ack1   (ack1),
      .gnt    (gnt)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                               input logic f, input logic chk, input logic ewr,
                               input logic [15:0] edata, input logic ea0,
                               input logic ea1, input logic [1:0] egnt);
      vec_t v;
      v.rst = rst;  v.r0 = r0;  v.r1 = r1;  v.f = f;  v.chk = chk;
      v.ewr = ewr;  v.edata = edata;  v.ea0 = ea0;  v.ea1 = ea1;
      v.egnt = egnt;  v.step = 0;
      return v;
   endfunction

   // Drive one cycle of inputs on the falling edge and queue what should
   // appear on the outputs for this cycle.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      stepNo++;
      reset = v.rst;
      req0  = v.r0;
      req1  = v.r1;
      full  = v.f;
      data0 = D0;
      data1 = D1;
      v.step = stepNo;
      if (v.chk) sbQ.push_back(v);
   endtask

   // Pop the oldest expectation and compare against the settled outputs.
   task automatic checkOutput();
      vec_t e;
      #1;
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checks++;
         if ({wr, w_data, ack0, ack1, gnt} !== {e.ewr, e.edata, e.ea0, e.ea1, e.egnt}) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got wr=%b w_data=%h ack0=%b ack1=%b gnt=%b, want wr=%b w_data=%h ack0=%b ack1=%b gnt=%b",
                     curSeq, e.step, wr, w_data, ack0, ack1, gnt,
                     e.ewr, e.edata, e.ea0, e.ea1, e.egnt);
         end
      end
   endtask

   task automatic step(input logic rst, input logic r0, input logic r1,
                       input logic f, input logic chk, input logic ewr,
                       input logic [15:0] edata, input logic ea0,
                       input logic ea1, input logic [1:0] egnt);
      applyStimulus(mk(rst, r0, r1, f, chk, ewr, edata, ea0, ea1, egnt));
      checkOutput();
   endtask

   task automatic doReset();
      step(1, 0, 0, 0, 0, 0, 16'h0, 0, 0, 2'b00);
   endtask

   // Every cycle outside reset: never write into a full FIFO, never ack both
   // ports, never ack a port that does not hold the grant.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!done && reset === 1'b0) begin
            checks++;
            if ((wr & full) !== 1'b0 || (ack0 & ack1) !== 1'b0 ||
                (ack0 & ~gnt[0]) !== 1'b0 || (ack1 & ~gnt[1]) !== 1'b0) begin
               errors++;
               $display("[TB] FAIL invariant at %0t: wr=%b full=%b ack0=%b ack1=%b gnt=%b",
                        $time, wr, full, ack0, ack1, gnt);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      full  = 1'b0;
      data0 = '0;
      data1 = '0;

      // Table: both ports held -> idle cycle, 4 on port 0, 4 on port 1, back to 0.
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 16'h0, 0, 0, 2'b00));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 0, 1, 1, D1, 0, 1, 2'b10));
      tbl.push_back(mk(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01));
      // Table: only port 1 -> continuous writes across burst boundaries.
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0, 0, 0, 2'b00));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 16'h0, 0, 0, 2'b00));
      for (int i = 0; i < 9; i++) tbl.push_back(mk(0, 0, 1, 0, 1, 1, D1, 0, 1, 2'b10));

      curSeq = "table";
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput();
      end

      // Full stall mid-burst: two writes, three stalled cycles, two more, then handoff.
      curSeq = "fullStall";
      doReset();
      step(0, 1, 0, 0, 1, 0, 16'h0, 0, 0, 2'b00);
      step(0, 1, 0, 0, 1, 1, D0, 1, 0, 2'b01);
      step(0, 1, 0, 0, 1, 1, D0, 1, 0, 2'b01);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 0, D0, 0, 0, 2'b01);
      step(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01);
      step(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01);
      step(0, 1, 1, 0, 1, 1, D1, 0, 1, 2'b10);

      // Port 0 drops after one write while port 1 waits: direct handoff.
      curSeq = "dropHandoff";
      doReset();
      step(0, 1, 1, 0, 1, 0, 16'h0, 0, 0, 2'b00);
      step(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01);
      step(0, 0, 1, 0, 1, 0, D0, 0, 0, 2'b01);
      step(0, 0, 1, 0, 1, 1, D1, 0, 1, 2'b10);

      // Reset during the third port-1 write; next tie must go to port 0.
      curSeq = "midReset";
      doReset();
      step(0, 1, 1, 0, 1, 0, 16'h0, 0, 0, 2'b00);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01);
      step(0, 1, 1, 0, 1, 1, D1, 0, 1, 2'b10);
      step(0, 1, 1, 0, 1, 1, D1, 0, 1, 2'b10);
      step(1, 1, 1, 0, 1, 1, D1, 0, 1, 2'b10);
      step(0, 1, 1, 0, 1, 0, 16'h0, 0, 0, 2'b00);
      step(0, 1, 1, 0, 1, 1, D0, 1, 0, 2'b01);

      // Request falls exactly at the last burst slot: no write, then idle.
      curSeq = "dropAtLast";
      doReset();
      step(0, 1, 0, 0, 1, 0, 16'h0, 0, 0, 2'b00);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 1, D0, 1, 0, 2'b01);
      step(0, 0, 0, 0, 1, 0, D0, 0, 0, 2'b01);
      step(0, 0, 0, 0, 1, 0, 16'h0, 0, 0, 2'b00);

      if (sbQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: %0d expectations left, want 0", sbQ.size());
      end

      @(negedge clk);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
